// File: rtl/roi_crop_stream_if.sv
// Valid/ready stream bundle carrying a data word plus row/frame markers.
// The same bundle type serves the config stream and both pixel streams.
interface roi_crop_stream_if #(
  parameter int DATA_W = 12
);
  logic [DATA_W-1:0] tdata;
  logic              tvalid;
  logic              tready;
  logic              tlast;
  logic              tuser;

  modport master (output tdata, tvalid, tlast, tuser, input tready);
  modport slave  (input tdata, tvalid, tlast, tuser, output tready);
endinterface

// File: rtl/roi_crop_stream.sv
// Runtime-configurable region-of-interest crop for raster pixel streams.
// A box {H, W, Y1, X1} is taken from the config stream at a frame boundary.
// Each input pixel inside the box is forwarded through a single output
// register with full-throughput backpressure. TLAST marks the last column
// of each clipped box row and TUSER marks the first forwarded pixel of a frame.
module roi_crop_stream #(
  parameter int PIXEL_BIT_WIDTH  = 12,
  parameter int NUM_CHANNELS     = 1,
  parameter int IN_ROWS          = 40,
  parameter int IN_COLS          = 40,
  parameter int IMG_ROW_BITWIDTH = 10,
  parameter int IMG_COL_BITWIDTH = 10,
  parameter int CFG_PERSIST      = 0
) (
  input  logic              clk,
  input  logic              reset,
  roi_crop_stream_if.slave  cfg,
  roi_crop_stream_if.slave  pixel_in,
  roi_crop_stream_if.master pixel_out,
  output logic              frame_done
);

  localparam int R     = IMG_ROW_BITWIDTH;
  localparam int C     = IMG_COL_BITWIDTH;
  localparam int PIX_W = PIXEL_BIT_WIDTH * NUM_CHANNELS;
  localparam bit PERSIST = (CFG_PERSIST != 0);
  localparam logic [C-1:0] X_LAST = C'(IN_COLS - 1);
  localparam logic [R-1:0] Y_LAST = R'(IN_ROWS - 1);

  typedef enum logic {
    WAIT_CFG = 1'b0,
    STREAM   = 1'b1
  } state_t;

  state_t state;
  state_t state_nx;

  // Shadow box; only rewritten while no pixel of the current frame is in.
  logic [C-1:0] x1;
  logic [R-1:0] y1;
  logic [C-1:0] w;
  logic [R-1:0] h;

  // Raster position of the next input pixel.
  logic [C-1:0] x_cnt;
  logic [R-1:0] y_cnt;
  logic [C-1:0] x_nx;
  logic [R-1:0] y_nx;

  logic sof_pending;
  logic cfg_win;

  logic [PIX_W-1:0] data_p1;
  logic             vld_p1;
  logic             last_p1;
  logic             user_p1;

  logic cfg_hs;
  logic boundary_take;
  logic in_ready;
  logic in_hs;
  logic at_frame_end;
  logic pass;

  // Sideband markers on the inbound streams carry no meaning here.
  logic unused_sideband;
  assign unused_sideband = ^{cfg.tlast, cfg.tuser, pixel_in.tlast, pixel_in.tuser};

  // Column membership, evaluated one bit wider so X1+W cannot wrap.
  function automatic logic col_in_box(input logic [C-1:0] pos,
                                      input logic [C-1:0] start,
                                      input logic [C-1:0] len);
    logic [C:0] p;
    logic [C:0] s;
    logic [C:0] e;
    p = {1'b0, pos};
    s = {1'b0, start};
    e = s + {1'b0, len};
    return (p >= s) && (p < e);
  endfunction

  // Row membership, evaluated one bit wider so Y1+H cannot wrap.
  function automatic logic row_in_box(input logic [R-1:0] pos,
                                      input logic [R-1:0] start,
                                      input logic [R-1:0] len);
    logic [R:0] p;
    logic [R:0] s;
    logic [R:0] e;
    p = {1'b0, pos};
    s = {1'b0, start};
    e = s + {1'b0, len};
    return (p >= s) && (p < e);
  endfunction

  // Last column of the box row after clipping at the image edge.
  function automatic logic col_is_last(input logic [C-1:0] pos,
                                       input logic [C-1:0] start,
                                       input logic [C-1:0] len);
    logic [C:0] nxt;
    logic [C:0] e;
    nxt = {1'b0, pos} + {{C{1'b0}}, 1'b1};
    e   = {1'b0, start} + {1'b0, len};
    return (nxt == e) || (pos == X_LAST);
  endfunction

  // cfg_win is the registered cfg_TREADY. It is open in WAIT_CFG and, when
  // persisting, at the origin of a frame before its first pixel is taken.
  assign cfg.tready    = cfg_win;
  assign cfg_hs        = cfg_win & cfg.tvalid;
  // A config taken in STREAM wins the cycle, so no pixel may enter with it.
  assign boundary_take = (state == STREAM) & cfg_hs;
  assign in_ready      = (state == STREAM) & (~vld_p1 | pixel_out.tready) & ~boundary_take;
  assign pixel_in.tready = in_ready;
  assign in_hs         = in_ready & pixel_in.tvalid;
  assign at_frame_end  = in_hs & (x_cnt == X_LAST) & (y_cnt == Y_LAST);
  assign pass          = in_hs & col_in_box(x_cnt, x1, w) & row_in_box(y_cnt, y1, h);

  // Next state and raster position for the control register below.
  always_comb begin
    state_nx = state;
    x_nx     = x_cnt;
    y_nx     = y_cnt;
    case (state)
      WAIT_CFG: begin
        if (cfg_hs) state_nx = STREAM;
      end
      STREAM: begin
        if (in_hs) begin
          if (x_cnt == X_LAST) begin
            x_nx = '0;
            if (y_cnt == Y_LAST) begin
              y_nx = '0;
              if (!PERSIST) state_nx = WAIT_CFG;
            end else begin
              y_nx = y_cnt + {{(R-1){1'b0}}, 1'b1};
            end
          end else begin
            x_nx = x_cnt + {{(C-1){1'b0}}, 1'b1};
          end
        end
      end
      default: state_nx = WAIT_CFG;
    endcase
  end

  // Control FSM: state, counters, start-of-frame flag, cfg window, frame pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= WAIT_CFG;
      x_cnt       <= '0;
      y_cnt       <= '0;
      sof_pending <= 1'b1;
      cfg_win     <= 1'b1;
      frame_done  <= 1'b0;
    end else begin
      state      <= state_nx;
      x_cnt      <= x_nx;
      y_cnt      <= y_nx;
      frame_done <= at_frame_end;
      cfg_win    <= (state_nx == WAIT_CFG) |
                    (PERSIST & (x_nx == '0) & (y_nx == '0));
      if (in_hs) begin
        if (at_frame_end) sof_pending <= 1'b1;
        else if (pass)    sof_pending <= 1'b0;
      end
    end
  end

  // Shadow config capture on every accepted config beat.
  always_ff @(posedge clk) begin
    if (cfg_hs) begin
      {h, w, y1, x1} <= cfg.tdata;
    end
  end

  // ---- stage p0 (input handshake) -> stage p1 (output register) ----
  // Output register: load a passing pixel, otherwise empty on a drain.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
      last_p1 <= 1'b0;
      user_p1 <= 1'b0;
    end else if (pass) begin
      vld_p1  <= 1'b1;
      data_p1 <= pixel_in.tdata;
      last_p1 <= col_is_last(x_cnt, x1, w);
      user_p1 <= sof_pending;
    end else if (pixel_out.tready) begin
      vld_p1  <= 1'b0;
    end
  end

  assign pixel_out.tvalid = vld_p1;
  assign pixel_out.tdata  = data_p1;
  assign pixel_out.tlast  = last_p1;
  assign pixel_out.tuser  = user_p1;

endmodule
